// File: rtl/md_cache_pkg.sv
// Shared types, sizing constants and cell-addressing helpers for the MU velocity cache grid.
package md_cache_pkg;

    localparam int VEL_DATA_WIDTH = 32;
    localparam int VEL_PID_WIDTH  = 7;

    typedef struct packed {
        logic [VEL_DATA_WIDTH-1:0] vx;
        logic [VEL_DATA_WIDTH-1:0] vy;
        logic [VEL_DATA_WIDTH-1:0] vz;
    } velocity_t;

    // Counts run 0..NUM_PARTICLE_PER_CELL inclusive, so one bit wider than the particle address.
    function automatic int count_width(input int pid_width);
        return pid_width + 1;
    endfunction

    function automatic logic coord_in_range(input int coord, input int cells);
        return (coord >= 1) && (coord <= cells);
    endfunction

    function automatic int cell_index(input int x, input int y, input int z,
                                      input int cells_x, input int cells_y);
        return (z - 1) * cells_x * cells_y + (y - 1) * cells_x + (x - 1);
    endfunction

endpackage

// File: rtl/velocity_cache_bank.sv
// One grid cell: ping-pong velocity banks, write pointer, latched count, overflow flag
// and a two-stage read pipeline (RAM register, then gated output register).
module velocity_cache_bank
    import md_cache_pkg::*;
#(
    parameter  int DATA_WIDTH = VEL_DATA_WIDTH,
    parameter  int DEPTH      = 128,
    parameter  int PID_WIDTH  = VEL_PID_WIDTH,
    localparam int CNT_WIDTH  = count_width(PID_WIDTH),
    localparam int VW         = 3 * DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bank_sel,
    input  logic                 swap,
    input  logic                 rd_en,
    input  logic [PID_WIDTH-1:0] rd_addr,
    input  logic                 wr_en,
    input  logic [VW-1:0]        wr_data,
    output logic [VW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    logic [VW-1:0] mem_0 [DEPTH];
    logic [VW-1:0] mem_1 [DEPTH];

    logic [CNT_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 overflow_d, overflow_q;
    logic                 rd_hit_d, rd_hit_q;
    logic                 rd_valid_d, rd_valid_q;
    logic [VW-1:0]        rd_data_d, rd_data_q;
    logic [VW-1:0]        ram_dout_q;
    logic                 ram_we;
    logic                 wr_bank;
    logic [PID_WIDTH-1:0] wr_addr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ram_we     = 1'b0;
        wr_bank    = ~bank_sel;
        wr_addr    = wr_ptr_q[PID_WIDTH-1:0];
        // A write landing on the swap edge belongs to the freshly emptied write bank.
        if (swap) begin
            count_d  = wr_ptr_q;
            wr_ptr_d = '0;
            wr_bank  = bank_sel;
            wr_addr  = '0;
        end
        if (wr_en) begin
            if (!swap && (wr_ptr_q == CNT_WIDTH'(DEPTH))) begin
                overflow_d = 1'b1;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = swap ? CNT_WIDTH'(1) : wr_ptr_q + CNT_WIDTH'(1);
            end
        end
        rd_hit_d   = rd_en && (CNT_WIDTH'(rd_addr) < count_q);
        rd_valid_d = rd_hit_q;
        rd_data_d  = rd_hit_q ? ram_dout_q : '0;
    end

    always_ff @(posedge clk) begin
        if (ram_we && !wr_bank) mem_0[wr_addr] <= wr_data;
        if (ram_we &&  wr_bank) mem_1[wr_addr] <= wr_data;
        if (rd_en) ram_dout_q <= bank_sel ? mem_1[rd_addr] : mem_0[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_hit_q   <= rd_hit_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/velocity_cache_array.sv
// CELLS_X x CELLS_Y x CELLS_Z grid of ping-pong velocity caches with swap-edge detection,
// bank select and destination-cell decode for the motion-update stage.
module velocity_cache_array
    import md_cache_pkg::*;
#(
    parameter  int CELLS_X               = 4,
    parameter  int CELLS_Y               = 4,
    parameter  int CELLS_Z               = 4,
    parameter  int DATA_WIDTH            = VEL_DATA_WIDTH,
    parameter  int CELL_ID_WIDTH         = 3,
    parameter  int NUM_PARTICLE_PER_CELL = 128,
    parameter  int PARTICLE_ID_WIDTH     = VEL_PID_WIDTH,
    localparam int NUM_CELLS             = CELLS_X * CELLS_Y * CELLS_Z,
    localparam int CNT_WIDTH             = count_width(PARTICLE_ID_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  Motion_Update_enable,
    input  logic [PARTICLE_ID_WIDTH-1:0]          MU_rd_addr,
    input  logic                                  MU_rden,
    input  logic [3*DATA_WIDTH-1:0]               MU_wr_data,
    input  logic [3*CELL_ID_WIDTH-1:0]            MU_dst_cell,
    input  logic                                  MU_wr_data_valid,
    output logic [NUM_CELLS-1:0][3*DATA_WIDTH-1:0] velocity_data_out,
    output logic [NUM_CELLS-1:0]                  velocity_data_valid,
    output logic [NUM_CELLS-1:0][CNT_WIDTH-1:0]   cell_particle_count,
    output logic [NUM_CELLS-1:0]                  overflow,
    output logic                                  dst_err,
    output logic                                  bank_sel
);

    logic en_d, en_q;
    logic swap_d, swap_q;
    logic bank_sel_d, bank_sel_q;
    logic dst_err_d, dst_err_q;
    logic rd_acc, wr_acc, dst_ok;
    int   dst_x, dst_y, dst_z, dst_idx;
    logic [NUM_CELLS-1:0] cell_we;

    always_comb begin
        dst_x   = int'(MU_dst_cell[3*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH]);
        dst_y   = int'(MU_dst_cell[2*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH]);
        dst_z   = int'(MU_dst_cell[CELL_ID_WIDTH-1:0]);
        dst_ok  = coord_in_range(dst_x, CELLS_X) && coord_in_range(dst_y, CELLS_Y)
               && coord_in_range(dst_z, CELLS_Z);
        dst_idx = cell_index(dst_x, dst_y, dst_z, CELLS_X, CELLS_Y);
        rd_acc  = MU_rden && Motion_Update_enable;
        wr_acc  = MU_wr_data_valid && Motion_Update_enable;
        cell_we = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cell_we[i] = wr_acc && dst_ok && (dst_idx == i);
        end
        // Falling enable is registered once more so the last in-pass write has settled.
        en_d       = Motion_Update_enable;
        swap_d     = en_q && !Motion_Update_enable;
        bank_sel_d = bank_sel_q ^ swap_q;
        dst_err_d  = dst_err_q || (wr_acc && !dst_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            swap_q     <= 1'b0;
            bank_sel_q <= 1'b0;
            dst_err_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            swap_q     <= swap_d;
            bank_sel_q <= bank_sel_d;
            dst_err_q  <= dst_err_d;
        end
    end

    for (genvar gz = 0; gz < CELLS_Z; gz++) begin : g_z
        for (genvar gy = 0; gy < CELLS_Y; gy++) begin : g_y
            for (genvar gx = 0; gx < CELLS_X; gx++) begin : g_x
                localparam int IDX = gz * CELLS_X * CELLS_Y + gy * CELLS_X + gx;
                velocity_cache_bank #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .DEPTH      (NUM_PARTICLE_PER_CELL),
                    .PID_WIDTH  (PARTICLE_ID_WIDTH)
                ) u_bank (
                    .clk      (clk),
                    .rst      (rst),
                    .bank_sel (bank_sel_q),
                    .swap     (swap_q),
                    .rd_en    (rd_acc),
                    .rd_addr  (MU_rd_addr),
                    .wr_en    (cell_we[IDX]),
                    .wr_data  (MU_wr_data),
                    .rd_data  (velocity_data_out[IDX]),
                    .rd_valid (velocity_data_valid[IDX]),
                    .count    (cell_particle_count[IDX]),
                    .overflow (overflow[IDX])
                );
            end
        end
    end

    assign dst_err  = dst_err_q;
    assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_velocity_cache_array.sv
// Directed-plus-random bench for velocity_cache_array against a queue-based cache model.
module tb_velocity_cache_array;
    import md_cache_pkg::*;

    localparam int NC = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 Motion_Update_enable;
    logic [6:0]           MU_rd_addr;
    logic                 MU_rden;
    logic [95:0]          MU_wr_data;
    logic [8:0]           MU_dst_cell;
    logic                 MU_wr_data_valid;
    logic [NC-1:0][95:0]  velocity_data_out;
    logic [NC-1:0]        velocity_data_valid;
    logic [NC-1:0][7:0]   cell_particle_count;
    logic [NC-1:0]        overflow;
    logic                 dst_err;
    logic                 bank_sel;

    int checks   = 0;
    int failures = 0;

    velocity_t  wr_bank [NC][$];
    velocity_t  rd_bank [NC][$];
    logic       m_bank_sel;
    logic [NC-1:0] m_ovf;
    logic       m_dst_err;
    logic [6:0] rd_list [16];
    int         rd_n;

    velocity_cache_array dut (
        .clk                  (clk),
        .rst                  (rst),
        .Motion_Update_enable (Motion_Update_enable),
        .MU_rd_addr           (MU_rd_addr),
        .MU_rden              (MU_rden),
        .MU_wr_data           (MU_wr_data),
        .MU_dst_cell          (MU_dst_cell),
        .MU_wr_data_valid     (MU_wr_data_valid),
        .velocity_data_out    (velocity_data_out),
        .velocity_data_valid  (velocity_data_valid),
        .cell_particle_count  (cell_particle_count),
        .overflow             (overflow),
        .dst_err              (dst_err),
        .bank_sel             (bank_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic velocity_t rand_vel();
        velocity_t v;
        v.vx = $urandom();
        v.vy = $urandom();
        v.vz = $urandom();
        return v;
    endfunction

    task automatic model_write(input int x, input int y, input int z, input velocity_t v);
        int idx;
        if (x < 1 || x > 4 || y < 1 || y > 4 || z < 1 || z > 4) begin
            m_dst_err = 1'b1;
        end else begin
            idx = (z - 1) * 16 + (y - 1) * 4 + (x - 1);
            if (wr_bank[idx].size() == 128) m_ovf[idx] = 1'b1;
            else wr_bank[idx].push_back(v);
        end
    endtask

    task automatic model_swap();
        for (int c = 0; c < NC; c++) begin
            rd_bank[c] = wr_bank[c];
            wr_bank[c].delete();
        end
        m_bank_sel = ~m_bank_sel;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            rd_bank[c].delete();
            wr_bank[c].delete();
        end
        m_bank_sel = 1'b0;
        m_ovf      = '0;
        m_dst_err  = 1'b0;
    endtask

    function automatic logic [96:0] exp_read(input int c, input logic [6:0] a);
        if (Motion_Update_enable && int'(a) < rd_bank[c].size()) return {1'b1, rd_bank[c][a]};
        return '0;
    endfunction

    task automatic wr(input int x, input int y, input int z, input velocity_t v);
        MU_wr_data_valid = 1'b1;
        MU_dst_cell      = {3'(x), 3'(y), 3'(z)};
        MU_wr_data       = v;
        tick();
        MU_wr_data_valid = 1'b0;
        if (Motion_Update_enable) model_write(x, y, z, v);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_bank_sel"}, 128'(bank_sel), 128'(m_bank_sel));
        chk({tag, "_dst_err"}, 128'(dst_err), 128'(m_dst_err));
        chk({tag, "_overflow"}, 128'(overflow), 128'(m_ovf));
        for (int c = 0; c < NC; c++)
            chk($sformatf("%s_count[%0d]", tag, c), 128'(cell_particle_count[c]),
                128'(rd_bank[c].size()));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 128'(velocity_data_valid), 128'(0));
        for (int c = 0; c < NC; c++)
            chk($sformatf("%s_data[%0d]", tag, c), 128'(velocity_data_out[c]), 128'(0));
        check_state(tag);
    endtask

    task automatic run_reads(input string tag);
        logic [96:0] e [16][NC];
        for (int k = 0; k <= rd_n; k++) begin
            if (k < rd_n) begin
                MU_rden    = 1'b1;
                MU_rd_addr = rd_list[k];
                for (int c = 0; c < NC; c++) e[k][c] = exp_read(c, rd_list[k]);
            end else begin
                MU_rden = 1'b0;
            end
            tick();
            if (k >= 1) begin
                for (int c = 0; c < NC; c++) begin
                    chk($sformatf("%s%0d_valid[%0d]", tag, k - 1, c),
                        128'(velocity_data_valid[c]), 128'(e[k-1][c][96]));
                    chk($sformatf("%s%0d_data[%0d]", tag, k - 1, c),
                        128'(velocity_data_out[c]), 128'(e[k-1][c][95:0]));
                end
            end
        end
    endtask

    task automatic begin_pass();
        Motion_Update_enable = 1'b1;
        tick();
    endtask

    task automatic end_pass(input string tag);
        logic old_sel;
        old_sel = m_bank_sel;
        Motion_Update_enable = 1'b0;
        tick();
        chk({tag, "_presw_sel"}, 128'(bank_sel), 128'(old_sel));
        tick();
        model_swap();
        check_state(tag);
    endtask

    initial begin
        logic [96:0] e5 [NC];
        velocity_t   v;
        int          lx, ly, lz;
        logic [6:0]  la;

        rst = 1'b1;
        Motion_Update_enable = 1'b0;
        MU_rden = 1'b0;
        MU_wr_data_valid = 1'b0;
        MU_rd_addr = '0;
        MU_wr_data = '0;
        MU_dst_cell = '0;
        model_reset();

        #2 rst = 1'b0;
        #1;
        check_zero("por");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // strobes with enable low are ignored; then three writes to cell (2,3,1)
        wr(2, 3, 1, rand_vel());
        rd_n = 1;
        rd_list[0] = 7'd0;
        run_reads("idle_rd");
        begin_pass();
        for (int i = 0; i < 3; i++) wr(2, 3, 1, rand_vel());
        end_pass("p1");
        begin_pass();
        rd_n = 4;
        for (int i = 0; i < 4; i++) rd_list[i] = 7'(i);
        run_reads("p1_rd");
        end_pass("p1e");

        // fill cell (1,1,1) past capacity
        begin_pass();
        for (int i = 0; i < 129; i++) wr(1, 1, 1, rand_vel());
        end_pass("ovf");
        begin_pass();
        rd_n = 4;
        rd_list[0] = 7'd0;
        rd_list[1] = 7'd1;
        rd_list[2] = 7'd126;
        rd_list[3] = 7'd127;
        run_reads("ovf_rd");

        // out-of-range destinations
        wr(0, 1, 1, rand_vel());
        wr(5, 2, 2, rand_vel());
        end_pass("dst");

        // random traffic
        begin_pass();
        for (int i = 0; i < 40; i++)
            wr($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), rand_vel());
        end_pass("rnd");
        begin_pass();
        rd_n = 12;
        for (int i = 0; i < 12; i++) rd_list[i] = 7'($urandom_range(0, 5));
        run_reads("rnd_rd");

        // write and read together in the last enable-high cycle
        for (int i = 0; i < 5; i++)
            wr($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), rand_vel());
        lx = $urandom_range(1, 4);
        ly = $urandom_range(1, 4);
        lz = $urandom_range(1, 4);
        v  = rand_vel();
        la = 7'($urandom_range(0, 2));
        for (int c = 0; c < NC; c++) e5[c] = exp_read(c, la);
        MU_wr_data_valid = 1'b1;
        MU_dst_cell      = {3'(lx), 3'(ly), 3'(lz)};
        MU_wr_data       = v;
        MU_rden          = 1'b1;
        MU_rd_addr       = la;
        tick();
        model_write(lx, ly, lz, v);
        MU_wr_data_valid = 1'b0;
        MU_rden = 1'b0;
        Motion_Update_enable = 1'b0;
        tick();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("last_rd_valid[%0d]", c), 128'(velocity_data_valid[c]), 128'(e5[c][96]));
            chk($sformatf("last_rd_data[%0d]", c), 128'(velocity_data_out[c]), 128'(e5[c][95:0]));
        end
        tick();
        model_swap();
        check_state("last");
        begin_pass();
        rd_n = 6;
        for (int i = 0; i < 6; i++) rd_list[i] = 7'($urandom_range(0, 3));
        run_reads("last_rdb");

        // asynchronous reset mid-pass with writes pending
        for (int i = 0; i < 10; i++) wr(3, 2, 4, rand_vel());
        MU_rden = 1'b1;
        MU_rd_addr = 7'd0;
        tick();
        tick();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("mid_rst");
        MU_rden = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        wr(3, 2, 4, rand_vel());
        wr(3, 2, 4, rand_vel());
        end_pass("post_rst");
        begin_pass();
        rd_n = 3;
        for (int i = 0; i < 3; i++) rd_list[i] = 7'(i);
        run_reads("post_rst_rd");
        end_pass("fin");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/velocity_cache_array.md
# velocity_cache_array

Parametrised 3-D array of per-cell velocity caches for the motion-update (MU) stage. It replaces the fixed 4x4x4 hand-instantiated cache set with a generate-based grid of CELLS_X x CELLS_Y x CELLS_Z cells. Each cell is ping-pong banked: MU reads old velocities from the read bank while updated velocities are appended to the write bank of their destination cell. Banks swap at the end of each MU pass, and the cell particle counts are latched at the same point.

## Interface
- CELLS_X / CELLS_Y / CELLS_Z, 4 / 4 / 4: grid dimensions; NUM_CELLS = product.
- DATA_WIDTH, 32: width of one velocity component.
- CELL_ID_WIDTH, 3: width of one cell coordinate.
- NUM_PARTICLE_PER_CELL, 128: depth of each bank.
- PARTICLE_ID_WIDTH, 7: width of the particle address.

- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- Motion_Update_enable  in  1  MU pass active; its falling edge triggers a swap.
- MU_rd_addr  in  PARTICLE_ID_WIDTH  particle address, broadcast to every cell.
- MU_rden  in  1  read strobe.
- MU_wr_data  in  3*DATA_WIDTH  {vx,vy,vz}.
- MU_dst_cell  in  3*CELL_ID_WIDTH  {x,y,z}; x in the MSBs; coordinates are 1-based.
- MU_wr_data_valid  in  1  write strobe.
- velocity_data_out  out  [NUM_CELLS-1:0][3*DATA_WIDTH]  per-cell read data.
- velocity_data_valid  out  NUM_CELLS  per-cell read valid.
- cell_particle_count  out  [NUM_CELLS-1:0][PARTICLE_ID_WIDTH+1]  particles in each read bank.
- overflow  out  NUM_CELLS  sticky flag: a write bank was full.
- dst_err  out  1  sticky flag: a write addressed an out-of-range cell.
- bank_sel  out  1  index of the current read bank.

## Operation
- Cell index = (z-1)*CELLS_X*CELLS_Y + (y-1)*CELLS_X + (x-1).
- Read accepted when MU_rden=1 and Motion_Update_enable=1:
  - every cell reads its read bank at MU_rd_addr;
  - velocity_data_valid[i] = (MU_rd_addr < cell_particle_count[i]);
  - when invalid, data is forced to 0.
- Write accepted when MU_wr_data_valid=1 and Motion_Update_enable=1:
  - coordinate 0 or > CELLS_* on any axis: write dropped, dst_err set;
  - target cell full (write pointer = NUM_PARTICLE_PER_CELL): write dropped, overflow[i] set;
  - otherwise: data stored at the cell's write pointer in its write bank, pointer +1.
- Strobes arriving with Motion_Update_enable=0 are ignored, with no side effects.
- Swap, on the cycle after enable is sampled 1 then 0:
  - bank_sel toggles;
  - cell_particle_count[i] takes the final write pointer value;
  - all write pointers clear to 0;
  - overflow is not cleared by a swap.
- A write in the last enable-high cycle is included in the latched count.
- Old write-bank contents are not cleared; reads are bounded by the count.
- Initial velocities are loaded as a normal MU pass (writes only), followed by a swap.
- dst_err and overflow clear only on reset.

## Timing
- Read latency 2 cycles: request at cycle t gives data and valid at t+2 (RAM stage, then output register). Reads are fully pipelined, one per cycle.
- A read in flight across a swap completes from the bank selected at issue, using the count captured at issue.
- Write-to-readable latency: visible only after the next swap.
- Swap edge: enable falling at cycle t (sampled low at edge t) gives bank_sel and counts updated at edge t+1.
- Reset values, applied immediately on asynchronous assertion:
  - bank_sel=0, counts=0, write pointers=0;
  - velocity_data_out=0, velocity_data_valid=0;
  - overflow=0, dst_err=0;
  - swap-detect register=0;
  - RAM contents unaffected.
- Reset deasserted mid-pass: the pass restarts from an empty state.

## Structure
- Package md_cache_pkg holds:
  - the cell-index function and the coordinate range check;
  - velocity_t (3*DATA_WIDTH packed struct {vx,vy,vz});
  - count-width constants.
- Sub-module velocity_cache_bank, one per cell via generate over z/y/x. It contains two NUM_PARTICLE_PER_CELL x 3*DATA_WIDTH simple dual-port RAMs, the write pointer, the latched count, the overflow flag and the read pipeline.
- The top level contains swap-edge detection, bank_sel, the destination decoder (one-hot write enable) and dst_err.

## Test plan
1. Assert rst low mid-clock → all outputs 0 at once, without waiting for a clock edge; bank_sel=0.
2. Write 3 particles to cell (2,3,1) (index 9), drop enable, then re-enable and read addresses 0..3:
   - count[9]=3, all other counts 0, bank_sel=1;
   - addresses 0–2: valid[9]=1 with the written data at t+2;
   - address 3: valid=0, data 0.
3. 129 writes to cell (1,1,1) → count[0]=128 after swap, overflow[0]=1, 129th value never read back.
4. Writes to (0,1,1) and (5,2,2) → dst_err=1, all counts unchanged after swap.
5. Write issued in the last enable-high cycle, plus a read issued one cycle before the swap:
   - the write is counted;
   - the read returns data from the old bank at t+2.
6. Pulse rst low during a pass with 10 writes pending → counts 0, bank_sel 0; the next pass starts with all write pointers at 0.
